// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded controls and datapath values from ID, inserts a bubble
// on a taken branch/jump flush or on a load-use hazard, and counts stall cycles.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,

  // register specifiers and operand usage of the instruction in ID
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic [4:0]  IF_ID_rd,
  input  logic        ID_uses_rs1,
  input  logic        ID_uses_rs2,

  // decoded controls
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_MemToReg,
  input  logic        ID_ALUSrc,
  input  logic        ID_Branch,
  input  logic [1:0]  ID_ALUOp,

  // datapath values
  input  logic [31:0] ID_pc,
  input  logic [31:0] ID_rs1_data,
  input  logic [31:0] ID_rs2_data,
  input  logic [31:0] ID_imm,

  // taken branch/jump resolved in EX
  input  logic        EX_flush,

  // registered copies
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic        ID_EX_uses_rs1,
  output logic        ID_EX_uses_rs2,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_MemToReg,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_Branch,
  output logic [1:0]  ID_EX_ALUOp,
  output logic [31:0] ID_EX_pc,
  output logic [31:0] ID_EX_rs1_data,
  output logic [31:0] ID_EX_rs2_data,
  output logic [31:0] ID_EX_imm,
  output logic        ID_EX_valid,

  // front-end enables and stall observability
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic bubble;

  // Load-use detection: a valid load in EX whose destination (not x0) is
  // actually read by the instruction in ID. A flush overrides the stall since
  // the ID instruction is being discarded anyway.
  always_comb begin
    rs1_hit     = ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1);
    rs2_hit     = ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2);
    hazard      = ID_EX_MemRead && ID_EX_valid && (ID_EX_rd != '0) && (rs1_hit || rs2_hit);
    stall       = hazard && !EX_flush;
    PC_write    = !stall;
    IF_ID_write = !stall;
    bubble      = EX_flush || stall;
  end

  // Pipeline register: all-zero bubble on flush/stall, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_rs1      <= '0;
      ID_EX_rs2      <= '0;
      ID_EX_rd       <= '0;
      ID_EX_uses_rs1 <= 1'b0;
      ID_EX_uses_rs2 <= 1'b0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_Branch   <= 1'b0;
      ID_EX_ALUOp    <= '0;
      ID_EX_pc       <= '0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_imm      <= '0;
      ID_EX_valid    <= 1'b0;
    end else if (bubble) begin
      ID_EX_rs1      <= '0;
      ID_EX_rs2      <= '0;
      ID_EX_rd       <= '0;
      ID_EX_uses_rs1 <= 1'b0;
      ID_EX_uses_rs2 <= 1'b0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_Branch   <= 1'b0;
      ID_EX_ALUOp    <= '0;
      ID_EX_pc       <= '0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_imm      <= '0;
      ID_EX_valid    <= 1'b0;
    end else begin
      ID_EX_rs1      <= IF_ID_rs1;
      ID_EX_rs2      <= IF_ID_rs2;
      ID_EX_rd       <= IF_ID_rd;
      ID_EX_uses_rs1 <= ID_uses_rs1;
      ID_EX_uses_rs2 <= ID_uses_rs2;
      ID_EX_RegWrite <= ID_RegWrite;
      ID_EX_MemRead  <= ID_MemRead;
      ID_EX_MemWrite <= ID_MemWrite;
      ID_EX_MemToReg <= ID_MemToReg;
      ID_EX_ALUSrc   <= ID_ALUSrc;
      ID_EX_Branch   <= ID_Branch;
      ID_EX_ALUOp    <= ID_ALUOp;
      ID_EX_pc       <= ID_pc;
      ID_EX_rs1_data <= ID_rs1_data;
      ID_EX_rs2_data <= ID_rs2_data;
      ID_EX_imm      <= ID_imm;
      ID_EX_valid    <= 1'b1;
    end
  end

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed and random
// instructions, a reference model predicts the register contents after each
// edge, and a monitor compares them one time unit after every rising edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr, mw, m2r, as, br;
    logic [1:0]  op;
    logic [31:0] pc, d1, d2, imm;
    logic        v;
  } ins_t;

  typedef struct packed {
    ins_t        r;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ins_t cur = '0;
  logic flush = 1'b0;

  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_u1, o_u2, o_rw, o_mr, o_mw, o_m2r, o_as, o_br, o_v;
  logic [1:0]  o_op;
  logic [31:0] o_pc, o_d1, o_d2, o_imm;
  logic        PC_write, IF_ID_write, stall;
  logic [15:0] stall_cnt;
  ins_t        got;

  assign got = {o_rs1, o_rs2, o_rd, o_u1, o_u2, o_rw, o_mr, o_mw, o_m2r, o_as, o_br,
                o_op, o_pc, o_d1, o_d2, o_imm, o_v};

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(cur.rs1), .IF_ID_rs2(cur.rs2), .IF_ID_rd(cur.rd),
    .ID_uses_rs1(cur.u1), .ID_uses_rs2(cur.u2),
    .ID_RegWrite(cur.rw), .ID_MemRead(cur.mr), .ID_MemWrite(cur.mw),
    .ID_MemToReg(cur.m2r), .ID_ALUSrc(cur.as), .ID_Branch(cur.br), .ID_ALUOp(cur.op),
    .ID_pc(cur.pc), .ID_rs1_data(cur.d1), .ID_rs2_data(cur.d2), .ID_imm(cur.imm),
    .EX_flush(flush),
    .ID_EX_rs1(o_rs1), .ID_EX_rs2(o_rs2), .ID_EX_rd(o_rd),
    .ID_EX_uses_rs1(o_u1), .ID_EX_uses_rs2(o_u2),
    .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr), .ID_EX_MemWrite(o_mw),
    .ID_EX_MemToReg(o_m2r), .ID_EX_ALUSrc(o_as), .ID_EX_Branch(o_br), .ID_EX_ALUOp(o_op),
    .ID_EX_pc(o_pc), .ID_EX_rs1_data(o_d1), .ID_EX_rs2_data(o_d2), .ID_EX_imm(o_imm),
    .ID_EX_valid(o_v),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .stall(stall), .stall_cnt(stall_cnt)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  // reference model state: the instruction the pipeline register should hold
  ins_t        m_reg = '0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic mr);
    ins_t i;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.u1 = u1; i.u2 = u2; i.mr = mr;
    i.rw  = $urandom_range(0, 1); i.mw = $urandom_range(0, 1); i.m2r = $urandom_range(0, 1);
    i.as  = $urandom_range(0, 1); i.br = $urandom_range(0, 1); i.op = 2'($urandom_range(0, 3));
    i.pc  = $urandom; i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
    i.v   = 1'b0;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    return mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
  endfunction

  // A valid load in EX writing a real register that ID actually reads.
  function automatic logic uses_loaded(input ins_t ex, input ins_t id);
    if (!(ex.v && ex.mr) || ex.rd == 5'd0) return 1'b0;
    return (id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd);
  endfunction

  task automatic drive(input ins_t i, input logic f);
    @(negedge clk);
    cur   = i;
    flush = f;
    #1;
  endtask

  // Check the combinational outputs for the applied inputs, then advance the
  // model by one edge and queue the expected register contents.
  task automatic commit();
    logic s;
    s = uses_loaded(m_reg, cur) && !flush;
    chk("stall", 160'(stall), 160'(s));
    chk("pc_write", 160'(PC_write), 160'(!s));
    chk("if_id_write", 160'(IF_ID_write), 160'(!s));
    if (flush || s) m_reg = '0;
    else begin
      m_reg   = cur;
      m_reg.v = 1'b1;
    end
    if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    q.push_back('{m_reg, m_cnt});
  endtask

  task automatic step(input ins_t i, input logic f);
    drive(i, f);
    commit();
  endtask

  // monitor: one expected entry per rising edge once traffic starts
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_ex_reg", 160'({got, stall_cnt}), 160'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ins_t ld, use_i, self_ld;

    // asynchronous reset takes effect without a clock edge
    #1;
    chk("reset_regs", 160'({got, stall_cnt}), 160'(0));
    chk("reset_stall", 160'({stall, PC_write, IF_ID_write}), 160'(3'b011));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // load x5 followed by a reader of x5: exactly one stall cycle
    ld    = mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
    use_i = mk(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
    step(ld, 1'b0);
    step(use_i, 1'b0);
    chk("loaduse_stall", 160'({stall, PC_write, IF_ID_write}), 160'(3'b100));
    step(use_i, 1'b0);
    chk("after_bubble_nostall", 160'(stall), 160'(0));
    @(posedge clk); #1;
    chk("loaduse_cnt", 160'(stall_cnt), 160'(1));

    // load into x0 never stalls
    step(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0);
    step(mk(5'd0, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0), 1'b0);
    chk("x0_load_nostall", 160'(stall), 160'(0));

    // rs2 match only matters when rs2 is actually used
    step(mk(5'd1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1), 1'b0);
    drive(mk(5'd2, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0), 1'b0);
    chk("rs2_unused_nostall", 160'(stall), 160'(0));
    cur.u2 = 1'b1;
    #1;
    chk("rs2_used_stall", 160'(stall), 160'(1));
    commit();

    // flush wins over a pending hazard
    step(mk(5'd1, 5'd1, 5'd10, 1'b0, 1'b0, 1'b1), 1'b0);
    step(mk(5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0), 1'b1);
    chk("flush_priority", 160'({stall, PC_write}), 160'(2'b01));

    // saturation: preset the counter just below the top, then two stalls
    self_ld = mk(5'd12, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
    step(self_ld, 1'b0);
    drive(self_ld, 1'b0);
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    m_cnt = 16'hFFFE;
    commit();
    step(self_ld, 1'b0);
    step(self_ld, 1'b0);
    step(mk(5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0), 1'b0);
    @(posedge clk); #1;
    chk("cnt_saturated", 160'(stall_cnt), 160'(16'hFFFF));

    // reset mid-stall clears everything before the next edge
    step(mk(5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b1), 1'b0);
    drive(mk(5'd13, 5'd2, 5'd14, 1'b1, 1'b1, 1'b0), 1'b0);
    chk("pre_reset_stall", 160'(stall), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("midstall_reset_regs", 160'({got, stall_cnt}), 160'(0));
    chk("midstall_reset_stall", 160'(stall), 160'(0));
    rst_n = 1'b1;
    m_reg = '0;
    m_cnt = '0;
    commit();

    // random traffic
    for (int unsigned n = 0; n < 500; n++) begin
      step(rand_ins(), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 160'(q.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have: clk  input  1  single clock, rising-edge active; one clock, all state in this domain.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have: IF_ID_rs1, IF_ID_rs2, IF_ID_rd  input  5 each  register specifiers of the decoding instruction.
REQ-004 SHALL have: ID_uses_rs1, ID_uses_rs2  input  1 each  decoded instruction actually reads rs1/rs2.
REQ-005 SHALL have: ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Branch  input  1 each  decoded controls.
REQ-006 SHALL have: ID_ALUOp  input  2  decoded ALU op class.
REQ-007 SHALL have: ID_pc, ID_rs1_data, ID_rs2_data, ID_imm  input  32 each  ID-stage datapath values.
REQ-008 SHALL have: EX_flush  input  1  branch/jump resolved taken in EX; kill the instruction in ID.
REQ-009 SHALL have: ID_EX_<field>  output  widths as inputs  registered copies of REQ-003..007 (ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_RegWrite, ... ID_EX_imm); rs1/rs2/rd/RegWrite feed the forwarding unit.
REQ-010 SHALL have: ID_EX_valid  output  1  register holds a real instruction (0 = bubble).
REQ-011 SHALL have: PC_write, IF_ID_write  output  1 each  combinational enables for PC and IF/ID register.
REQ-012 SHALL have: stall  output  1  combinational load-use stall indication.
REQ-013 SHALL have: stall_cnt  output  16  registered count of stall cycles.

Function
REQ-014 hazard SHALL be 1 iff ID_EX_MemRead && ID_EX_valid && ID_EX_rd!=0 && ((ID_uses_rs1 && ID_EX_rd==IF_ID_rs1) || (ID_uses_rs2 && ID_EX_rd==IF_ID_rs2)).
REQ-015 stall SHALL equal hazard && !EX_flush; PC_write and IF_ID_write SHALL equal !stall.
REQ-016 Each rising edge, if EX_flush or stall: register SHALL load a bubble (every ID_EX_ output 0, ID_EX_valid 0).
REQ-017 Otherwise register SHALL load all ID_ inputs, ID_EX_valid <= 1.
REQ-018 EX_flush SHALL take priority over hazard: bubble inserted, stall=0, PC_write=1, stall_cnt unchanged.
REQ-019 Bubble with rd=0 and RegWrite=0 SHALL never trigger forwarding or a further hazard; one load-use produces exactly one stall cycle.
REQ-020 rd=x0 load SHALL never stall (REQ-014); rs field matching with uses_rs=0 SHALL never stall.
REQ-021 stall_cnt SHALL increment by 1 on each edge where stall=1, saturating at 16'hFFFF (no wrap).
REQ-022 Latency: ID inputs SHALL appear on ID_EX_ outputs one cycle after capture; no combinational path from ID_ data inputs to ID_EX_ outputs.

Reset
REQ-023 rst_n low SHALL immediately clear every ID_EX_ output, ID_EX_valid and stall_cnt to 0 without waiting for clk.
REQ-024 After reset, stall=0, PC_write=1, IF_ID_write=1 until a load is captured.
REQ-025 Reset asserted mid-stall SHALL clear state; first edge after rst_n rises SHALL capture ID inputs normally.

Verification
REQ-026 Load x5 (MemRead=1, rd=5) captured, next ID reads rs1=5 uses_rs1=1 -> stall=1, PC_write=0, IF_ID_write=0; next edge ID_EX_valid=0, ID_EX_rd=0, stall_cnt=1; following cycle stall=0 and instruction captured.
REQ-027 Load rd=0 followed by rs1=0 -> stall=0, no bubble, stall_cnt stays 0.
REQ-028 Load rd=7, next ID rs2=7 with uses_rs2=0 -> stall=0; with uses_rs2=1 -> stall=1.
REQ-029 Hazard cycle with EX_flush=1 -> stall=0, PC_write=1, bubble captured, stall_cnt unchanged.
REQ-030 Force stall_cnt to 16'hFFFE, two stall cycles -> 16'hFFFF, then remains 16'hFFFF.
REQ-031 Assert rst_n=0 between edges with valid non-zero contents -> all ID_EX_ outputs and stall_cnt read 0 before next clk edge.
